uart_receiver: RTL
==================

# uart_receiver

Serial-to-parallel UART receive stage. Consumes the single-wire frame produced by the `transmitter` block and delivers each `MESSAGE_SIZE`-bit payload to the board-side logic as a parallel word with a one-cycle valid strobe. Frame format and baud timing match the transmitter exactly: start bit 0, `MESSAGE_SIZE` data bits LSB first, stop bit 1, `CLKS_PER_BIT` clocks per bit. Frames whose stop bit reads 0 are reported as framing errors.

## Interface
- `MESSAGE_SIZE`, default global `MESSAGE_SIZE` from `constants.svh`: payload width in bits.
- `CLKS_PER_BIT`, default 2604: clocks per bit period. Must be ≥ 4 and must match the transmitter.
- `clk`  in  1  system clock; all logic runs on the rising edge. One clock domain only.
- `rst`  in  1  reset, asynchronous, active-high.
- `RxD`  in  1  serial input. Asynchronous to `clk`. Idles high.
- `data`  out  `MESSAGE_SIZE`  last correctly framed payload. Holds until the next good frame.
- `data_valid`  out  1  one-cycle pulse; `data` is updated in the same cycle.
- `frame_error`  out  1  one-cycle pulse when a bad stop bit is sampled.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Input synchronizer: two flops, both reset to 1. `rx_s` is the second flop's output, and all decisions use `rx_s`.
- `HALF` = `CLKS_PER_BIT`/2 (integer division). Baud counter width = clog2(`CLKS_PER_BIT`). Bit index width = clog2(`MESSAGE_SIZE`+1).
- FSM states:
  - IDLE: counter = 0. If `rx_s`==0, go to START.
  - START: counter increments. When counter == `HALF`-1:
    - if `rx_s`==0: go to DATA, counter = 0, bit index = 0.
    - else: treat as a glitch, return to IDLE with no output pulse.
  - DATA: counter increments. When counter == `CLKS_PER_BIT`-1:
    - shift `rx_s` into the MSB of the shift register (right shift, so the first bit received ends at bit 0).
    - counter = 0, bit index +1.
    - after sample number `MESSAGE_SIZE`, go to STOP.
  - STOP: when counter == `CLKS_PER_BIT`-1, sample `rx_s`:
    - if 1: load `data` from the shift register, pulse `data_valid`, go to IDLE.
    - if 0: pulse `frame_error`, leave `data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This prevents a break condition from retriggering reception.
- Every sample is taken at mid-bit: `HALF` clocks into the start bit, then whole bit periods after that.
- `data_valid` and `frame_error` are registered and never asserted together.
- Reset values: state IDLE, `data` = 0, `data_valid` = 0, `frame_error` = 0, `busy` = 0, synchronizer = 1, counters = 0, shift register = 0.
- Reset mid-frame: the partial frame is discarded and no pulse is produced. After release, the block re-arms on the next falling edge of `rx_s`.
- There is no backpressure. The consumer must capture `data` on `data_valid`. A new frame overwrites `data` only on its own `data_valid`.

## Timing
- Clock 0 = first `clk` edge sampling `RxD` low. `rx_s` goes low after edge 1, and START is entered at edge 2.
- `data_valid` is asserted at edge 2 + `HALF` + (`MESSAGE_SIZE`+1)·`CLKS_PER_BIT` (±0). Example: with `CLKS_PER_BIT`=16 and `MESSAGE_SIZE`=8, this is clock 154.
- The stop-bit decision falls at mid stop bit. IDLE is re-entered with at least `HALF` clocks of stop bit remaining, so back-to-back frames with a 1-bit stop and no idle gap are received without loss.
- A start-bit glitch shorter than `HALF`-2 clocks is rejected.
- `busy` rises the cycle after START is entered and falls the cycle after the STOP decision, or after exit from WAIT_HIGH.

## Test plan
- Reset and idle: hold `RxD`=1 with `rst` pulsed mid-run → all outputs 0, `busy`=0, no pulses for 10·`CLKS_PER_BIT` clocks.
- Single frame (`CLKS_PER_BIT`=16, `MESSAGE_SIZE`=8): send 0xA5 → exactly one `data_valid` at clock 154, `data`=0xA5, `frame_error` never asserted.
- Back-to-back loopback: connect a `transmitter` instance (same parameters, `CLKS_PER_BIT`=2604) to `RxD` and drive 0x00, 0xFF, 0x3C, 0x81 → four `data_valid` pulses whose `data` matches each word in order, with no errors.
- Glitch rejection: drive `RxD` low for 4 clocks (`CLKS_PER_BIT`=16), then high → no pulse, return to IDLE; a following frame with payload 0x5A is received correctly.
- Framing error: send 0x33 with stop bit 0, holding `RxD` low 3 more bit periods → one `frame_error` pulse, `data` keeps its previous value, `busy` stays high until `RxD` returns high, and the next good frame (0x44) is received.
- Reset mid-frame: assert `rst` during data bit 4 of a frame carrying 0x77 → no `data_valid`, `data`=0. A subsequent frame with payload 0x12 yields `data`=0x12.

Source files
------------

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receiver: start/data/stop framing, mid-bit sampling, framing-error detect
module uart_receiver #(
  parameter int MESSAGE_SIZE = 8,
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RxD,
  output logic [MESSAGE_SIZE-1:0] data,
  output logic                    data_valid,
  output logic                    frame_error,
  output logic                    busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(MESSAGE_SIZE + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(MESSAGE_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_sync1;
  logic                    r_sync2;
  logic [CW-1:0]           r_cnt;
  logic [BW-1:0]           r_bit_idx;
  logic [MESSAGE_SIZE-1:0] r_shift;
  logic [MESSAGE_SIZE-1:0] r_data;
  logic                    r_data_valid;
  logic                    r_frame_error;
  logic                    r_busy;

  logic w_rx_s;
  logic w_start_done;
  logic w_bit_done;
  logic w_cnt_clr;
  logic w_bit_clr;
  logic w_shift_en;
  logic w_load;
  logic w_ferr;

  assign w_rx_s       = r_sync2;
  assign w_start_done = (r_cnt == HALF_M1);
  assign w_bit_done   = (r_cnt == BIT_M1);

  assign data        = r_data;
  assign data_valid  = r_data_valid;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

  // Two-flop synchronizer for the asynchronous serial line; idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RxD;
      r_sync2 <= r_sync1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: mid-start-bit check rejects glitches, WAIT_HIGH swallows a break
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_state_next = S_START;
      end
      S_START: begin
        if (w_start_done) w_state_next = w_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_bit_done && (r_bit_idx == LAST_BIT)) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_done) w_state_next = w_rx_s ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output/control decode: counter clears, sample strobes, stop-bit verdict
  always_comb begin
    w_cnt_clr  = 1'b0;
    w_bit_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_load     = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
      end
      S_START: begin
        w_cnt_clr = w_start_done;
        w_bit_clr = w_start_done;
      end
      S_DATA: begin
        w_cnt_clr  = w_bit_done;
        w_shift_en = w_bit_done;
      end
      S_STOP: begin
        w_cnt_clr = w_bit_done;
        w_load    = w_bit_done & w_rx_s;
        w_ferr    = w_bit_done & ~w_rx_s;
      end
      S_WAIT_HIGH: begin
        w_cnt_clr = 1'b1;
      end
      default: begin
        w_cnt_clr = 1'b1;
      end
    endcase
  end

  // Baud counter and bit index; start decision restarts timing at mid start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      if (w_bit_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + BW'(1);
      end
    end
  end

  // Right-shifting receive register: the first (LSB) bit ends up at bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_shift <= {w_rx_s, r_shift[MESSAGE_SIZE-1:1]};
    end
  end

  // Registered outputs: data only changes on a good stop bit; pulses are mutually exclusive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_load) r_data <= r_shift;
      r_data_valid  <= w_load;
      r_frame_error <= w_ferr;
      r_busy        <= (r_state != S_IDLE);
    end
  end

endmodule
